// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, fixed 32-iteration latency
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [2:0]  op_r;
  logic [4:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] opd;
  logic        neg;

  // Operand conditioning at acceptance: magnitudes plus the final sign to apply.
  logic        a_signed, b_signed, a_neg, b_neg, neg_in;
  logic [31:0] abs_a, abs_b;

  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed & a[31];
    b_neg    = b_signed & b[31];
    abs_a    = a_neg ? (32'd0 - a) : a;
    abs_b    = b_neg ? (32'd0 - b) : b;
    case (op)
      3'b001, 3'b010: neg_in = a_neg ^ b_neg;
      3'b100:         neg_in = (a_neg ^ b_neg) & (b != 32'd0);
      3'b110:         neg_in = a_neg;
      default:        neg_in = 1'b0;
    endcase
  end

  // One radix-2 step: hi holds partial product / partial remainder, lo the
  // shifting multiplier / dividend-into-quotient.
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [31:0] nhi, nlo;

  always_comb begin
    mul_sum  = {1'b0, hi} + {1'b0, opd};
    div_sh   = {hi, lo[31]};
    div_ge   = div_sh >= {1'b0, opd};
    div_diff = div_sh[31:0] - opd;
    nhi      = hi;
    nlo      = lo;
    if (op_r[2]) begin
      if (div_ge) begin
        nhi = div_diff;
        nlo = {lo[30:0], 1'b1};
      end else begin
        nhi = div_sh[31:0];
        nlo = {lo[30:0], 1'b0};
      end
    end else if (lo[0]) begin
      {nhi, nlo} = {mul_sum, lo[31:1]};
    end else begin
      {nhi, nlo} = {1'b0, hi, lo[31:1]};
    end
  end

  logic [63:0] prod, sprod;
  logic [31:0] quo, rem, fin_res;

  always_comb begin
    prod  = {nhi, nlo};
    sprod = neg ? (64'd0 - prod) : prod;
    quo   = neg ? (32'd0 - nlo) : nlo;
    rem   = neg ? (32'd0 - nhi) : nhi;
    case (op_r)
      3'b000:                 fin_res = sprod[31:0];
      3'b001, 3'b010, 3'b011: fin_res = sprod[63:32];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= 3'd0;
      cnt    <= 5'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      opd    <= 32'd0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r  <= op;
            neg   <= neg_in;
            hi    <= 32'd0;
            lo    <= op[2] ? abs_a : abs_b;
            opd   <= op[2] ? abs_b : abs_a;
            cnt   <= 5'd31;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          hi <= nhi;
          lo <= nlo;
          if (cnt == 5'd0) begin
            result <= fin_res;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed bench for muldiv_unit with arithmetic reference model
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 32'd0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 32'd0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference timing: accept in idle, done 32 edges later, idle one edge after that.
  logic        m_busy, m_done;
  logic [31:0] m_res, m_exp;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_res = 32'd0; m_left = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_left = 32; m_exp = ref_op(op, a, b);
      end
    end else if (m_done) begin
      m_busy = 1'b0; m_done = 1'b0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1; m_res = m_exp;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("result", result, m_res);
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input string nm);
    int n;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (done || n >= 40) break;
      start = (n == 3);
      a = $urandom;
      @(posedge clk);
      n++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, n, 32);
    chk(nm, result, exp);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x, y, e;
    string       nm;
  } vec_t;

  vec_t vecs[14];

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("model_mul", ref_op(3'd0, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("model_mulhsu", ref_op(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);
    chk("model_div", ref_op(3'd4, 32'hFFFFFF9C, 32'd7), 32'hFFFFFFF2);
    chk("model_rem", ref_op(3'd6, 32'hFFFFFF9C, 32'd7), 32'hFFFFFFFE);

    vecs = '{
      '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, "mul"},
      '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, "mulh"},
      '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu"},
      '{3'd2, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, "mulhsu"},
      '{3'd5, 32'd100,        32'd7,        32'd14,       "divu"},
      '{3'd7, 32'd100,        32'd7,        32'd2,        "remu"},
      '{3'd4, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, "div_neg"},
      '{3'd6, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE, "rem_neg"},
      '{3'd4, 32'd5,          32'd0,        32'hFFFFFFFF, "div_by0"},
      '{3'd6, 32'd5,          32'd0,        32'd5,        "rem_by0"},
      '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, "div_ovf"},
      '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        "rem_ovf"},
      '{3'd4, 32'hFFFFFF9C,   32'd0,        32'hFFFFFFFF, "div_negby0"},
      '{3'd7, 32'hDEADBEEF,   32'd0,        32'hDEADBEEF, "remu_by0"}
    };
    foreach (vecs[i]) run_op(vecs[i].o, vecs[i].x, vecs[i].y, vecs[i].e, vecs[i].nm);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] rx, ry;
      rx = $urandom; ry = (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      run_op(3'(i), rx, ry, ref_op(3'(i), rx, ry), "rand");
    end

    // Abort mid-calculation: re-pulsed start is ignored, reset wins.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; a = 32'd200; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_after_rst");

    repeat (5) @(posedge clk);
    #1 chk("hold_result", result, 32'd14);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
